// File: rtl/fifo_rd_adapter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_rd_adapter
// Description : Turns a FIFO read port (request, data one cycle later) into a
//               registered valid/ready stream backed by a 2-entry buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_rd_adapter #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ffrempty,
    output logic          ffrreq,
    input  logic [DW-1:0] ffrdata,
    input  logic          ffrvld,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [1:0]    occ,
    output logic          err
);

    localparam logic [1:0] c_OCC_EMPTY = 2'd0;
    localparam logic [1:0] c_OCC_ONE   = 2'd1;
    localparam logic [1:0] c_OCC_FULL  = 2'd2;

    logic [DW-1:0] r_head;
    logic [DW-1:0] r_tail;
    logic [1:0]    r_occ;
    logic          r_inflight;
    logic          r_mask;
    logic          r_err;

    logic          w_pop;
    logic          w_cap;
    logic          w_drop;
    logic [2:0]    w_credit;

    assign w_pop  = m_valid & m_ready;
    assign w_cap  = ffrvld & ~r_mask;
    assign w_drop = w_cap & (r_occ == c_OCC_FULL) & ~w_pop;

    // Slots already promised: buffered beats plus the read still in flight,
    // less the beat leaving this cycle. Three bits so the sum never wraps.
    assign w_credit = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign ffrreq   = ~reset & ~ffrempty & (w_credit < 3'd2);

    assign m_valid = (r_occ != c_OCC_EMPTY);
    assign m_data  = r_head;
    assign occ     = r_occ;
    assign err     = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_occ      <= c_OCC_EMPTY;
            r_inflight <= 1'b0;
            r_mask     <= 1'b1;
            r_err      <= 1'b0;
        end else begin
            r_mask     <= 1'b0;
            r_inflight <= ffrreq;

            if (w_drop) begin
                r_err <= 1'b1;
            end else begin
                if (w_cap && !w_pop) begin
                    r_occ <= r_occ + 2'd1;
                end else if (!w_cap && w_pop) begin
                    r_occ <= r_occ - 2'd1;
                end

                if (w_cap) begin
                    if ((r_occ == c_OCC_EMPTY) || ((r_occ == c_OCC_ONE) && w_pop)) begin
                        r_head <= ffrdata;
                    end else begin
                        r_tail <= ffrdata;
                    end
                end

                // Head is never written by capture when full, so the shift is safe.
                if (w_pop && (r_occ == c_OCC_FULL)) begin
                    r_head <= r_tail;
                end
            end

            if (w_cap && !r_inflight) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_rd_adapter
// Description : Randomized bench for fifo_rd_adapter against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_rd_adapter;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          ffrempty;
    logic          ffrreq;
    logic [DW-1:0] ffrdata;
    logic          ffrvld;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [1:0]    occ;
    logic          err;

    always #5 clk = ~clk;

    fifo_rd_adapter #(.DW(DW)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .ffrempty (ffrempty),
        .ffrreq   (ffrreq),
        .ffrdata  (ffrdata),
        .ffrvld   (ffrvld),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .occ      (occ),
        .err      (err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: output buffer and upstream FIFO as plain queues.
    logic [DW-1:0] q[$];
    logic [DW-1:0] src[$];
    bit            md_inflight;
    bit            md_err;
    bit            md_mask;
    bit            md_pend;
    logic [DW-1:0] md_pend_data;
    bit            rst_prev;
    bit            exp_req;
    bit            pop;
    bit            cap;
    int            credit;

    typedef struct {
        int ready_pct;
        int inj_pct;
        int rst_pct;
        int fill_pct;
        int cycles;
    } phase_t;

    phase_t phases[6];

    initial begin
        phases[0] = '{100, 0,  0, 100, 40};   // streaming
        phases[1] = '{0,   0,  0, 100, 30};   // backpressure
        phases[2] = '{100, 0,  0, 100, 30};   // release
        phases[3] = '{10,  15, 0, 80,  150};  // overflow / unrequested
        phases[4] = '{60,  4,  4, 60,  400};  // mixed with resets
        phases[5] = '{50,  3,  2, 30,  400};  // sparse upstream

        reset    = 1'b1;
        m_ready  = 1'b0;
        ffrvld   = 1'b0;
        ffrdata  = '0;
        ffrempty = 1'b1;
        @(posedge clk);
        md_inflight = 0;
        md_err      = 0;
        md_mask     = 1;
        md_pend     = 0;
        rst_prev    = 1;

        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < phases[p].cycles; c++) begin
                @(negedge clk);
                if (src.size() < 4 && $urandom_range(99) < phases[p].fill_pct)
                    src.push_back(DW'($urandom));
                reset    = ($urandom_range(99) < phases[p].rst_pct);
                m_ready  = ($urandom_range(99) < phases[p].ready_pct);
                ffrempty = (src.size() == 0);
                if (md_pend) begin
                    ffrvld  = 1'b1;
                    ffrdata = md_pend_data;
                end else begin
                    ffrvld  = ($urandom_range(99) < phases[p].inj_pct);
                    ffrdata = DW'($urandom);
                end

                pop     = (q.size() != 0) && m_ready;
                credit  = q.size() + int'(md_inflight) - int'(pop);
                exp_req = !reset && !ffrempty && (credit < 2);

                #1;
                check("ffrreq",  32'(ffrreq),  32'(exp_req));
                check("m_valid", 32'(m_valid), 32'(q.size() != 0));
                check("occ",     32'(occ),     32'(q.size()));
                check("err",     32'(err),     32'(md_err));
                if (q.size() != 0)
                    check("m_data", 32'(m_data), 32'(q[0]));
                else if (rst_prev)
                    check("m_data_rst", 32'(m_data), 32'h0);

                // Advance the model across the coming rising edge.
                if (reset) begin
                    q.delete();
                    md_inflight = 0;
                    md_err      = 0;
                    md_mask     = 1;
                end else begin
                    cap = ffrvld && !md_mask;
                    if (cap && !md_inflight) md_err = 1;
                    if (pop) void'(q.pop_front());
                    if (cap) begin
                        if (q.size() < 2) q.push_back(ffrdata);
                        else md_err = 1;
                    end
                    md_inflight = exp_req;
                    md_mask     = 0;
                end
                rst_prev = reset;
                md_pend  = exp_req;
                if (exp_req) md_pend_data = src.pop_front();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
